fx3_bus_in_buffer: RTL

Receive-side buffer directly downstream of the FX3 bus input path. Captures FX3 data words qualified by the in-path's data-valid strobe into a first-word-fall-through FIFO and presents them to the user side as a valid/ready stream. It also generates the read flow-control signal that the in-path checks before starting a packet, and it marks the last word of every packet.

---
 rtl/fx3_bus_in_buffer_if.sv | 33 +++
 rtl/fx3_bus_in_buffer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/fx3_bus_in_buffer_if.sv
// Signal bundle between the FX3 in-path / user stream side and fx3_bus_in_buffer.
// The master modport drives the in-path and user-side inputs; the slave modport is the buffer.
interface fx3_bus_in_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
);
  logic [DATA_WIDTH-1:0] i_fx3_data;
  logic                  i_data_valid;
  logic [23:0]           i_packet_size;
  logic                  o_read_flow_cntrl;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_data_valid;
  logic                  o_data_last;
  logic                  i_data_ready;
  logic [ADDR_WIDTH:0]   o_fill_count;
  logic                  o_full;
  logic                  o_empty;
  logic                  o_packet_done;
  logic                  o_overflow;
  logic                  i_clear_overflow;

  modport master (
    output i_fx3_data, i_data_valid, i_packet_size, i_data_ready, i_clear_overflow,
    input  o_read_flow_cntrl, o_data, o_data_valid, o_data_last, o_fill_count,
           o_full, o_empty, o_packet_done, o_overflow
  );

  modport slave (
    input  i_fx3_data, i_data_valid, i_packet_size, i_data_ready, i_clear_overflow,
    output o_read_flow_cntrl, o_data, o_data_valid, o_data_last, o_fill_count,
           o_full, o_empty, o_packet_done, o_overflow
  );
endinterface

// File: rtl/fx3_bus_in_buffer.sv
// FX3 receive buffer: FWFT FIFO with registered valid/ready output, packet-last tracker and flow control.
// Optional FX3_IN_BUFFER_LAST_EN stores a last tag per word and drives o_data_last.
module fx3_bus_in_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  fx3_bus_in_buffer_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [24:0] DEPTH_25 = 25'(DEPTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
`ifdef FX3_IN_BUFFER_LAST_EN
  localparam int ENTRY_W = DATA_WIDTH + 1;
`else
  localparam int ENTRY_W = DATA_WIDTH;
`endif

  typedef enum logic {IDLE = 1'b0, RX = 1'b1} trk_state_t;

  function automatic logic flow_ok(input logic [ADDR_WIDTH:0] fill,
                                   input logic [23:0] psize,
                                   input logic ovf);
    logic [24:0] space;
    logic [24:0] need;
    space = DEPTH_25 - 25'(fill);
    need  = {1'b0, psize};
    return (psize != 24'd0) && (need <= DEPTH_25) && !ovf && (space >= need);
  endfunction

  logic [ENTRY_W-1:0]    mem [DEPTH];
  logic [ENTRY_W-1:0]    wr_entry;
  logic [ENTRY_W-1:0]    rd_entry;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   mem_cnt, mem_next;
  logic [ADDR_WIDTH:0]   fill_cnt, fill_next;
  logic                  full, push, pop, drop, load;
  logic [DATA_WIDTH-1:0] data_p1;
  logic                  vld_p1;
  logic                  pkt_done, ovf, flow;
  trk_state_t            trk_state, trk_next;
  logic [23:0]           wcnt, wcnt_next;
  logic [24:0]           pos_next;
  logic                  word_last;

  // A full buffer still takes a word when the output pops in the same cycle.
  assign full = (fill_cnt == DEPTH_CNT);
  assign pop  = vld_p1 && bus.i_data_ready;
  assign push = bus.i_data_valid && (!full || pop);
  assign drop = bus.i_data_valid && full && !pop;
  assign load = (mem_cnt != '0) && (!vld_p1 || pop);
  assign rd_entry = mem[rd_ptr];

  always_comb begin
    fill_next = fill_cnt;
    if (push && !pop)      fill_next = fill_cnt + CNT_ONE;
    else if (pop && !push) fill_next = fill_cnt - CNT_ONE;
  end

  always_comb begin
    mem_next = mem_cnt;
    if (push && !load)      mem_next = mem_cnt + CNT_ONE;
    else if (load && !push) mem_next = mem_cnt - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mem_cnt  <= '0;
      fill_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (load) rd_ptr <= rd_ptr + PTR_ONE;
      mem_cnt  <= mem_next;
      fill_cnt <= fill_next;
    end
  end

  // Output stage: storage head moves into the registered stream output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
    end else if (load) begin
      data_p1 <= rd_entry[DATA_WIDTH-1:0];
      vld_p1  <= 1'b1;
    end else if (pop) begin
      vld_p1  <= 1'b0;
    end
  end

`ifdef FX3_IN_BUFFER_LAST_EN
  logic last_p1;
  assign wr_entry = {word_last, bus.i_fx3_data};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last_p1 <= 1'b0;
    else if (load) last_p1 <= rd_entry[DATA_WIDTH];
    else if (pop)  last_p1 <= 1'b0;
  end
  assign bus.o_data_last = last_p1;
`else
  assign wr_entry = bus.i_fx3_data;
  assign bus.o_data_last = 1'b0;
`endif

  // Tracker counts every strobe, dropped or not, so framing survives overflow.
  always_comb begin
    trk_next  = trk_state;
    wcnt_next = wcnt;
    word_last = 1'b0;
    pos_next  = '0;
    if (bus.i_data_valid) begin
      pos_next = (trk_state == IDLE) ? 25'd1 : ({1'b0, wcnt} + 25'd1);
      if (pos_next == {1'b0, bus.i_packet_size}) begin
        word_last = 1'b1;
        wcnt_next = '0;
        trk_next  = IDLE;
      end else begin
        wcnt_next = pos_next[23:0];
        trk_next  = RX;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trk_state <= IDLE;
      wcnt      <= '0;
    end else begin
      trk_state <= trk_next;
      wcnt      <= wcnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_done <= 1'b0;
      ovf      <= 1'b0;
      flow     <= 1'b0;
    end else begin
      pkt_done <= bus.i_data_valid && word_last;
      if (drop)                      ovf <= 1'b1;
      else if (bus.i_clear_overflow) ovf <= 1'b0;
      flow <= flow_ok(fill_cnt, bus.i_packet_size, ovf);
    end
  end

  assign bus.o_data            = data_p1;
  assign bus.o_data_valid      = vld_p1;
  assign bus.o_fill_count      = fill_cnt;
  assign bus.o_full            = full;
  assign bus.o_empty           = (fill_cnt == '0);
  assign bus.o_packet_done     = pkt_done;
  assign bus.o_overflow        = ovf;
  assign bus.o_read_flow_cntrl = flow;

endmodule
